// File: rtl/fifo_axis_drain.sv
// Drains a first-word-fall-through FIFO into a valid/ready stream and adds tlast framing every PKT_LEN beats.
// A two-entry skid buffer lets the FIFO pop depend only on registered occupancy, never on m_tready.
module fifo_axis_drain #(
    parameter int WIDTH   = 32,
    parameter int PKT_LEN = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             r_ready,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tlast,
    output logic [15:0]      pkt_cnt
);

    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t              occ, occ_next;
    logic [WIDTH-1:0]  slot0, slot0_next;
    logic [WIDTH-1:0]  slot1, slot1_next;
    logic [BEAT_W-1:0] beat, beat_next;
    logic [15:0]       pkt_next;
    logic              pop, take;

    // Pop uses only registered occupancy and the FIFO flag, so no path from m_tready.
    assign pop      = !reset && !fifo_empty && (occ != TWO);
    assign r_ready  = pop;
    assign m_tvalid = (occ != EMPTY);
    assign take     = m_tvalid && m_tready;
    assign m_tdata  = slot0;
    assign m_tlast  = m_tvalid && (beat == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            occ     <= EMPTY;
            slot0   <= '0;
            slot1   <= '0;
            beat    <= '0;
            pkt_cnt <= '0;
        end else begin
            occ     <= occ_next;
            slot0   <= slot0_next;
            slot1   <= slot1_next;
            beat    <= beat_next;
            pkt_cnt <= pkt_next;
        end
    end

    always_comb begin
        occ_next   = occ;
        slot0_next = slot0;
        slot1_next = slot1;
        unique case (occ)
            EMPTY: begin
                if (pop) begin
                    slot0_next = fifo_data;
                    occ_next   = ONE;
                end
            end
            ONE: begin
                // Pop and take together keep streaming at one word per clock.
                if (pop && !take) begin
                    slot1_next = fifo_data;
                    occ_next   = TWO;
                end else if (pop && take) begin
                    slot0_next = fifo_data;
                end else if (take) begin
                    occ_next = EMPTY;
                end
            end
            TWO: begin
                if (take) begin
                    slot0_next = slot1;
                    occ_next   = ONE;
                end
            end
            default: begin
                occ_next = EMPTY;
            end
        endcase
    end

    always_comb begin
        beat_next = beat;
        pkt_next  = pkt_cnt;
        if (take) begin
            if (beat == LAST_BEAT) begin
                beat_next = '0;
                pkt_next  = pkt_cnt + 16'd1;
            end else begin
                beat_next = beat + BEAT_W'(1);
            end
        end
    end

endmodule

// File: doc/fifo_axis_drain.md
# fifo_axis_drain

Downstream drain stage for the `fifo` block. It pops words from the FIFO's read port using the `fifo_empty`/`r_ready` handshake and re-emits them on a valid/ready stream master with a `tlast` framing marker every `PKT_LEN` beats. A two-entry output buffer absorbs sink backpressure without a combinational path from `m_tready` to `r_ready`, so the FIFO can be drained at one word per clock. The block sits between the FIFO and the next streaming consumer, for example the FIR input or a DMA.

## Interface
Parameters:
- `WIDTH`, 32, data width; must equal the FIFO `WIDTH`.
- `PKT_LEN`, 8, beats per packet; ≥1. Beat counter width is max(1, $clog2(PKT_LEN)).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  WIDTH  FIFO `data_out`. First-word-fall-through: holds the head word whenever `fifo_empty`=0.
- `r_ready`  out  1  pop strobe to the FIFO; the head word is consumed on any edge where `r_ready`=1.
- `m_tvalid`  out  1  output beat valid.
- `m_tready`  in  1  sink accepts the beat.
- `m_tdata`  out  WIDTH  output beat data.
- `m_tlast`  out  1  last beat of a packet.
- `pkt_cnt`  out  16  completed-packet counter; wraps modulo 2^16.

## Operation
- Internal state:
  - `cnt` ∈ {0,1,2}, the number of buffered words.
  - `slot0` (head) and `slot1`.
  - `beat` counter, range 0..PKT_LEN-1.
  - `pkt_cnt`.
- Derived signals:
  - pop: `r_ready` = !reset && !fifo_empty && (cnt<2). Depends only on registered state and `fifo_empty`.
  - take: `m_tvalid` && `m_tready`.
- Outputs:
  - `m_tvalid` = (cnt≠0).
  - `m_tdata` = `slot0`.
  - `m_tlast` = `m_tvalid` && (beat == PKT_LEN-1).
- Buffer update, one row per case:
  - cnt=0, pop: `slot0`←`fifo_data`; cnt=1.
  - cnt=1, pop, no take: `slot1`←`fifo_data`; cnt=2.
  - cnt=1, pop, take: `slot0`←`fifo_data`; cnt stays 1 (full-rate streaming).
  - cnt=1, take, no pop: cnt=0.
  - cnt=2, take: `slot0`←`slot1`; cnt=1. No pop is possible at cnt=2.
  - No pop and no take: hold all state.
- Framing:
  - On take, `beat` increments. If `beat`==PKT_LEN-1, `beat`←0 and `pkt_cnt`←`pkt_cnt`+1 (wraps 0xFFFF→0).
  - With PKT_LEN=1, every beat has `m_tlast`=1.
- Word order is strictly preserved. No word is dropped or duplicated.
- Simultaneous events:
  - `fifo_empty` rising in the same cycle as a take: only the take applies.
  - `fifo_data` is ignored whenever `r_ready`=0.

## Timing
- Reset is synchronous and takes priority over all else:
  - cnt=0, `beat`=0, `pkt_cnt`=0, `slot0`=`slot1`=0.
  - Outputs during and after reset: `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `r_ready`=0 (also forced 0 during the reset cycle).
- Reset mid-operation: buffered words and the partial-packet beat count are discarded. The first beat after reset starts a new packet.
- Latency: head word present (`fifo_empty`=0) in cycle k with cnt<2 → popped at the end of cycle k → `m_tvalid`=1 with that word in cycle k+1.
- Throughput: 1 word/clock while `m_tready`=1 and the FIFO is non-empty.
- Backpressure:
  - While `m_tvalid`=1 and `m_tready`=0, `m_tdata` and `m_tlast` are held stable.
  - At most 2 further words are popped, after which `r_ready`=0 until a take.
- The sink may toggle `m_tready` freely. `m_tvalid` never deasserts without a take.

## Test plan
1. Reset then idle, `fifo_empty`=1 → `r_ready`=0, `m_tvalid`=0, `m_tlast`=0, `pkt_cnt`=0 for 10 cycles.
2. FIFO preloaded with 0..15, PKT_LEN=8, `m_tready`=1 constantly → first beat one cycle after the first pop, then 16 consecutive beats 0..15; `m_tlast` on words 7 and 15; `pkt_cnt`=2.
3. `m_tready`=0 with the FIFO holding 3 words {A,B,C} → exactly 2 pops, then `r_ready`=0; `m_tdata`=A held stable. Then `m_tready`=1 → A, B, C in order, no gaps.
4. Random `m_tready` (50%) and random FIFO refill over 200 words → output sequence equals input sequence exactly; `m_tlast` on every 8th beat; `pkt_cnt`=25.
5. Reset asserted after beat 3 of a packet with 2 words buffered → next cycle `m_tvalid`=0, `pkt_cnt`=0; the next word emitted after reset is beat 0, and `m_tlast` first appears 8 beats later.
6. PKT_LEN=1, 5 words → `m_tlast`=1 on all 5 beats; `pkt_cnt`=5.
